// File: rtl/regfile_scan.sv
// regfile_scan -- walks every register address of a register file.
//
// DUMP  (mode=0): reads each register through the read port, one per READ
//                 cycle, and offers (index, data) on a valid/ready stream.
// CLEAR (mode=1): drives the write port with zero, one register per cycle.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, mode        scan request and scan kind, sampled only in IDLE
//   busy, done         scan in progress / one-cycle completion pulse
//   rd_reg, rd_data    register file read port (rd_data combinational)
//   wt_reg, wt_data,
//   reg_write          register file write port (wt_data is always zero)
//   out_valid,
//   out_ready,
//   out_index,
//   out_data           dump stream; a word moves on an edge with valid&ready
//
// Every output is a register: each one is loaded on the edge that enters
// the state where it has to be visible, so rd_reg already holds the index
// during READ and wt_reg/reg_write already hold the target during CLEAR.
// NUM_REGS must not exceed 2**ADDR_W.
module regfile_scan #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_reg,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] wt_reg,
   output logic [DATA_W-1:0] wt_data,
   output logic              reg_write,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_index,
   output logic [DATA_W-1:0] out_data
);

   typedef enum logic [2:0] {IDLE, READ, SEND, CLEAR, DONE} stateT;

   // Terminal index; the counter stops here, so no address >= NUM_REGS is
   // ever driven and the counter never wraps.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   stateT             state;
   logic [ADDR_W-1:0] index;
   logic [ADDR_W-1:0] nextIdx;

   assign nextIdx = index + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         index     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_reg    <= '0;
         wt_reg    <= '0;
         wt_data   <= '0;
         reg_write <= 1'b0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_data  <= '0;
      end else begin
         done    <= 1'b0;
         wt_data <= '0;
         case (state)
            IDLE: begin
               // mode is only looked at here, which is what latches it for
               // the whole scan; start elsewhere is ignored.
               if (start) begin
                  index <= '0;
                  busy  <= 1'b1;
                  if (mode) begin
                     state     <= CLEAR;
                     wt_reg    <= '0;
                     reg_write <= 1'b1;
                  end else begin
                     state  <= READ;
                     rd_reg <= '0;
                  end
               end
            end

            READ: begin
               // rd_reg == index during this cycle, so rd_data is reg[index].
               out_data  <= rd_data;
               out_index <= index;
               out_valid <= 1'b1;
               state     <= SEND;
            end

            SEND: begin
               // out_valid is always 1 here; out_ready alone completes it.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (index == LAST_IDX) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     index  <= nextIdx;
                     rd_reg <= nextIdx;
                     state  <= READ;
                  end
               end
            end

            CLEAR: begin
               // The write for wt_reg happens on the edge leaving this cycle.
               if (index == LAST_IDX) begin
                  reg_write <= 1'b0;
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  index  <= nextIdx;
                  wt_reg <= nextIdx;
               end
            end

            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_scan.sv
// tb_regfile_scan -- directed sequence with randomized data and backpressure
// around regfile_scan. A behavioural register file sits on the DUT ports;
// expected dump words are derived from the bench's own copy of the register
// contents (index i -> refMem[i], in ascending order).
module tb_regfile_scan;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   logic              clk = 1'b0;
   logic              reset, start, mode, out_ready;
   logic              busy, done, reg_write, out_valid;
   logic [ADDR_W-1:0] rd_reg, wt_reg, out_index;
   logic [DATA_W-1:0] rd_data, wt_data, out_data;

   regfile_scan #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .busy(busy), .done(done),
      .rd_reg(rd_reg), .rd_data(rd_data),
      .wt_reg(wt_reg), .wt_data(wt_data), .reg_write(reg_write),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // Register file model; a synchronous reset cycle blocks the write.
   logic [DATA_W-1:0] mem     [NUM_REGS];
   logic [DATA_W-1:0] loadVal [NUM_REGS];
   logic [DATA_W-1:0] refMem  [NUM_REGS];
   logic              loadEn = 1'b0;

   always @(posedge clk) begin
      if (loadEn) mem <= loadVal;
      else if (reg_write && !reset) mem[wt_reg] <= wt_data;
   end
   assign rd_data = mem[rd_reg];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation, sampled on the falling edge.
   int wIdx[$], wData[$], wCyc[$], wrReg[$], wrCyc[$];
   int wrDataBad = 0, doneCnt = 0, doneCyc = 0, holdErr = 0;
   logic              prevStall = 1'b0;
   logic [ADDR_W-1:0] pIdx;
   logic [DATA_W-1:0] pData;

   always @(negedge clk) begin
      if (reset) begin
         prevStall <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            wIdx.push_back(int'(out_index));
            wData.push_back(int'(out_data));
            wCyc.push_back(cyc);
         end
         if (reg_write) begin
            wrReg.push_back(int'(wt_reg));
            wrCyc.push_back(cyc);
            if (wt_data !== '0) wrDataBad <= wrDataBad + 1;
         end
         if (done) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cyc;
         end
         if (prevStall && !(out_valid && out_index == pIdx && out_data == pData))
            holdErr <= holdErr + 1;
         prevStall <= out_valid && !out_ready;
         pIdx      <= out_index;
         pData     <= out_data;
      end
   end

   int checks = 0, errors = 0;
   int startCyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic load();
      @(posedge clk); #1;
      loadEn = 1'b1;
      @(posedge clk); #1;
      loadEn = 1'b0;
      refMem = loadVal;
   endtask

   task automatic startScan(input logic m);
      wIdx.delete(); wData.delete(); wCyc.delete();
      wrReg.delete(); wrCyc.delete();
      wrDataBad = 0;
      @(posedge clk); #1;
      start    = 1'b1;
      mode     = m;
      startCyc = cyc;
   endtask

   // Runs until a done pulse (bounded); optional random ready, a 5-cycle
   // stall on one word, and a stray start pulse at cycle pulseAt.
   task automatic runScan(input bit randReady, input int stallWord, input int pulseAt);
      int t = 0;
      int d0 = doneCnt;
      int stalled = 0;
      while (doneCnt == d0 && t < 2000) begin
         @(posedge clk); #1;
         t++;
         start = (t == pulseAt);
         mode  = (t == pulseAt);
         if (stallWord >= 0 && out_valid && int'(out_index) == stallWord && stalled < 5) begin
            check("stall_data", out_data, refMem[stallWord]);
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = randReady ? ($urandom_range(3) != 0) : 1'b1;
         end
      end
      check("scan_finished", doneCnt != d0, 1);
      if (stallWord >= 0) check("stall_cycles", stalled, 5);
      out_ready = 1'b1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("single_done", doneCnt - d0, 1);
   endtask

   task automatic checkDump(input string tag);
      int bad = 0;
      for (int i = 0; i < wIdx.size(); i++)
         if (wIdx[i] != i || wData[i] != int'(refMem[i])) bad++;
      check({tag, "_count"}, wIdx.size(), NUM_REGS);
      check({tag, "_words"}, bad, 0);
      check({tag, "_hold"}, holdErr, 0);
   endtask

   initial begin
      logic [82:0] snap0;
      int toggles = 0;
      int bad;
      int d0;
      int t;
      reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) loadVal[i] = 32'hA000_0000 + i;
      load();

      // Reset and idle quiet.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_regwrite", reg_write, 0);
      check("rst_valid", out_valid, 0);
      check("rst_addrs", {rd_reg, wt_reg, out_index}, 0);
      check("rst_data", {wt_data, out_data}, 0);
      snap0 = {busy, done, rd_reg, wt_reg, wt_data, reg_write, out_valid, out_index, out_data};
      repeat (10) begin
         @(negedge clk);
         if ({busy, done, rd_reg, wt_reg, wt_data, reg_write, out_valid, out_index, out_data} !== snap0)
            toggles++;
      end
      check("idle_quiet", toggles, 0);

      // Free-flowing dump of A000_0000+i.
      startScan(1'b0);
      runScan(1'b0, -1, 0);
      checkDump("dump_free");
      check("first_valid_lat", wCyc.size() > 0 ? wCyc[0] - startCyc : -1, 2);
      bad = 0;
      for (int i = 1; i < wCyc.size(); i++) if (wCyc[i] - wCyc[i-1] != 2) bad++;
      check("word_spacing", bad, 0);
      check("done_after_last", doneCyc, wCyc.size() > 0 ? wCyc[wCyc.size()-1] + 1 : -1);
      check("dump_no_write", wrReg.size(), 0);

      // Backpressure on word 3 plus random ready elsewhere.
      startScan(1'b0);
      runScan(1'b1, 3, 0);
      checkDump("dump_bp");

      // Random contents, random ready, stray CLEAR start mid-dump.
      for (int i = 0; i < NUM_REGS; i++) loadVal[i] = $urandom;
      load();
      startScan(1'b0);
      runScan(1'b1, -1, 9);
      checkDump("dump_busy_start");
      check("busy_start_no_write", wrReg.size(), 0);

      // Clear of all-ones registers, then a dump of zeros.
      for (int i = 0; i < NUM_REGS; i++) loadVal[i] = '1;
      load();
      startScan(1'b1);
      runScan(1'b0, -1, 0);
      check("clr_writes", wrReg.size(), NUM_REGS);
      check("clr_consecutive", wrCyc.size() > 0 ? wrCyc[wrCyc.size()-1] - wrCyc[0] : -1, NUM_REGS - 1);
      bad = 0;
      for (int i = 0; i < wrReg.size(); i++) if (wrReg[i] != i) bad++;
      check("clr_addr_seq", bad, 0);
      check("clr_wdata", wrDataBad, 0);
      for (int i = 0; i < NUM_REGS; i++) refMem[i] = '0;
      bad = 0;
      for (int i = 0; i < NUM_REGS; i++) if (mem[i] !== refMem[i]) bad++;
      check("clr_mem", bad, 0);
      startScan(1'b0);
      runScan(1'b0, -1, 0);
      checkDump("dump_zero");

      // Reset in the cycle that would write register 10.
      for (int i = 0; i < NUM_REGS; i++) loadVal[i] = '1;
      load();
      startScan(1'b1);
      @(posedge clk); #1 start = 1'b0;
      d0 = doneCnt;
      t = 0;
      while (!(reg_write && wt_reg == 10) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("rst_mid_reached", t < 200, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_regwrite", reg_write, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", out_valid, 0);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("rst_mid_no_done", doneCnt - d0, 0);
      bad = 0;
      for (int i = 0; i < NUM_REGS; i++)
         if (mem[i] !== ((i < 10) ? 32'h0 : 32'hFFFF_FFFF)) bad++;
      check("rst_mid_mem", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
